// File: rtl/noc_pkg.sv
// Shared NoC constants: flit type encodings, port indices and the type-field position.
package noc_pkg;

    localparam logic [1:0] FLIT_SINGLE = 2'b00;
    localparam logic [1:0] FLIT_HEAD   = 2'b01;
    localparam logic [1:0] FLIT_BODY   = 2'b10;
    localparam logic [1:0] FLIT_TAIL   = 2'b11;

    localparam int PORT_L = 0;
    localparam int PORT_N = 1;
    localparam int PORT_E = 2;
    localparam int PORT_S = 3;
    localparam int PORT_W = 4;

    localparam int TYPE_LSB = 0;
    localparam int TYPE_MSB = 1;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first requester at or above i_ptr wins, wrapping to bit 0.
module rr_arbiter #(
    parameter int N  = 5,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [PW-1:0] i_ptr,
    input  logic          i_en,
    output logic [N-1:0]  o_gnt
);

    localparam logic [N-1:0] ONE = N'(1);

    logic [N-1:0] w_mask;
    logic [N-1:0] w_hi;
    logic [N-1:0] w_pick;

    // Requesters at or above the pointer take priority; otherwise wrap to the full set.
    assign w_mask = ~((ONE << i_ptr) - ONE);
    assign w_hi   = i_req & w_mask;
    assign w_pick = (|w_hi) ? w_hi : i_req;
    assign o_gnt  = i_en ? (w_pick & (~w_pick + ONE)) : '0;

endmodule

// File: rtl/switch_alloc_rr.sv
// Switch allocator + crossbar: per-output round-robin arbitration, wormhole locking,
// and one registered output stage per port with full-based backpressure.
module switch_alloc_rr
    import noc_pkg::*;
#(
    parameter int NPORT    = 5,
    parameter int DATASIZE = 40,
    parameter int PTRW     = (NPORT > 1) ? $clog2(NPORT) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NPORT-1:0]          in_valid,
    input  logic [NPORT*NPORT-1:0]    in_dst,
    input  logic [NPORT*DATASIZE-1:0] in_data,
    output logic [NPORT-1:0]          in_ready,
    input  logic [NPORT-1:0]          out_full,
    output logic [NPORT-1:0]          out_valid,
    output logic [NPORT*DATASIZE-1:0] out_data
);

    localparam logic [NPORT-1:0] ONE = NPORT'(1);

    logic [NPORT-1:0][DATASIZE-1:0] w_in_data;
    logic [NPORT-1:0][DATASIZE-1:0] w_out_data;
    logic [NPORT-1:0][NPORT-1:0]    w_in_dst;
    logic [NPORT-1:0][NPORT-1:0]    w_dst_oh;
    logic [NPORT-1:0][NPORT-1:0]    w_req;
    logic [NPORT-1:0][NPORT-1:0]    w_gnt;

    assign w_in_data = in_data;
    assign w_in_dst  = in_dst;
    assign out_data  = w_out_data;

    // Isolate the lowest destination bit, then transpose to [output][input].
    always_comb begin
        w_dst_oh = '0;
        w_req    = '0;
        for (int i = 0; i < NPORT; i++) begin
            w_dst_oh[i] = w_in_dst[i] & (~w_in_dst[i] + ONE);
        end
        for (int o = 0; o < NPORT; o++) begin
            for (int i = 0; i < NPORT; i++) begin
                w_req[o][i] = in_valid[i] & w_dst_oh[i][o];
            end
        end
    end

    always_comb begin
        in_ready = '0;
        for (int o = 0; o < NPORT; o++) begin
            in_ready = in_ready | w_gnt[o];
        end
    end

    for (genvar o = 0; o < NPORT; o++) begin : g_out
        logic                r_valid;
        logic [DATASIZE-1:0] r_data;
        logic [PTRW-1:0]     r_ptr;
        logic                r_lock;
        logic [PTRW-1:0]     r_owner;

        logic                w_can_load;
        logic                w_any;
        logic [NPORT-1:0]    w_elig;
        logic [DATASIZE-1:0] w_mux;
        logic [PTRW-1:0]     w_gidx;
        logic [PTRW-1:0]     w_ptr_nxt;
        logic [1:0]          w_type;

        assign w_can_load = !r_valid || !out_full[o];
        assign w_elig     = r_lock ? (w_req[o] & (ONE << r_owner)) : w_req[o];

        rr_arbiter #(.N(NPORT), .PW(PTRW)) u_arb (
            .i_req (w_elig),
            .i_ptr (r_ptr),
            .i_en  (w_can_load),
            .o_gnt (w_gnt[o])
        );

        always_comb begin
            w_mux  = '0;
            w_gidx = '0;
            for (int i = 0; i < NPORT; i++) begin
                if (w_gnt[o][i]) begin
                    w_mux  = w_mux | w_in_data[i];
                    w_gidx = PTRW'(i);
                end
            end
        end

        assign w_any     = |w_gnt[o];
        assign w_type    = w_mux[TYPE_MSB:TYPE_LSB];
        assign w_ptr_nxt = (w_gidx == PTRW'(NPORT - 1)) ? '0 : w_gidx + PTRW'(1);

        // Blocked outputs hold everything, including arbitration state.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_valid <= 1'b0;
                r_data  <= '0;
                r_ptr   <= '0;
                r_lock  <= 1'b0;
                r_owner <= '0;
            end else if (w_can_load) begin
                r_valid <= w_any;
                if (w_any) begin
                    r_data <= w_mux;
                    r_ptr  <= w_ptr_nxt;
                    if (w_type == FLIT_HEAD) begin
                        r_lock  <= 1'b1;
                        r_owner <= w_gidx;
                    end else if (w_type == FLIT_TAIL && r_lock && r_owner == w_gidx) begin
                        r_lock <= 1'b0;
                    end
                end
            end
        end

        assign out_valid[o]  = r_valid;
        assign w_out_data[o] = r_data;
    end

endmodule
